// File: rtl/sram_1rw1r_ctrl.sv
// Request/response controller for a 1RW+1R SRAM macro.
// Channel A (read/write) drives macro port 0, channel B (read-only) drives
// macro port 1. Read data returns through per-channel response FIFOs whose
// space is reserved up front by a credit counter, so nothing is ever dropped.

// Response FIFO: power-of-two depth, pointers wrap naturally.
module RspFifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] pushData_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rdPtr_q];

  // Occupancy follows push/pop; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop_i)  rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  // Storage needs no reset; only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= pushData_i;
  end
endmodule

module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0] credA_q, credA_d, credB_q, credB_d;
  logic          aAccept, aReadAcc, aWriteAcc, bAccept, collide;
  logic          aPop, bPop;
  logic          aRd1_q, aRd2_q, bRd1_q, bRd2_q;

  // Writes never need response space; reads need a free credit.
  assign a_req_ready = a_req_we | (credA_q != '0);
  assign aAccept     = a_req_valid & a_req_ready;
  assign aReadAcc    = aAccept & ~a_req_we;
  assign aWriteAcc   = aAccept & a_req_we;
  // Port A wins when it writes the very word B wants to read this cycle.
  assign collide     = aWriteAcc & (a_req_addr == b_req_addr);
  assign b_req_ready = (credB_q != '0) & ~collide;
  assign bAccept     = b_req_valid & b_req_ready;
  assign aPop        = a_rsp_valid & a_rsp_ready;
  assign bPop        = b_rsp_valid & b_rsp_ready;

  // Credits = depth minus reads in flight minus FIFO occupancy.
  always_comb begin
    credA_d = credA_q;
    credB_d = credB_q;
    if (aReadAcc && !aPop) credA_d = credA_q - CW'(1);
    else if (!aReadAcc && aPop) credA_d = credA_q + CW'(1);
    if (bAccept && !bPop) credB_d = credB_q - CW'(1);
    else if (!bAccept && bPop) credB_d = credB_q + CW'(1);
  end

  // Credit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      credA_q <= CW'(RSP_DEPTH);
      credB_q <= CW'(RSP_DEPTH);
    end else begin
      credA_q <= credA_d;
      credB_q <= credB_d;
    end
  end

  // Registered macro pins: one cycle of chip select per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
      csb1   <= 1'b1;
      addr1  <= '0;
    end else begin
      csb0   <= ~aAccept;
      web0   <= ~aWriteAcc;
      wmask0 <= aWriteAcc ? a_req_wmask : '0;
      if (aAccept)   addr0 <= a_req_addr;
      if (aWriteAcc) din0  <= a_req_wdata;
      csb1   <= ~bAccept;
      if (bAccept)   addr1 <= b_req_addr;
    end
  end

  // Read tracking: stage 1 = pins driven, stage 2 = macro output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      aRd1_q <= 1'b0;
      aRd2_q <= 1'b0;
      bRd1_q <= 1'b0;
      bRd2_q <= 1'b0;
    end else begin
      aRd1_q <= aReadAcc;
      aRd2_q <= aRd1_q;
      bRd1_q <= bAccept;
      bRd2_q <= bRd1_q;
    end
  end

  RspFifo #(.DW(DATA_WIDTH), .DEPTH(RSP_DEPTH)) uFifoA (
    .clk       (clk),
    .rst       (rst),
    .push_i    (aRd2_q),
    .pushData_i(dout0),
    .pop_i     (aPop),
    .valid_o   (a_rsp_valid),
    .data_o    (a_rsp_rdata)
  );

  RspFifo #(.DW(DATA_WIDTH), .DEPTH(RSP_DEPTH)) uFifoB (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bRd2_q),
    .pushData_i(dout1),
    .pop_i     (bPop),
    .valid_o   (b_rsp_valid),
    .data_o    (b_rsp_rdata)
  );
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Directed bench for sram_1rw1r_ctrl with a behavioural 1RW+1R macro model.
module tb_sram_1rw1r_ctrl;
  logic        clk, rst;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [3:0]  a_req_wmask;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready;
  logic [7:0]  b_req_addr;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;

  int vecCount = 0;
  int missCount = 0;

  logic [31:0] sramMem [256];
  logic [31:0] refMem [256];

  sram_1rw1r_ctrl dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int k);
    return 32'hA500_0000 | (32'(k) * 32'h0001_0101);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sramMem[i] = initWord(i);
  end

  // Macro model: captures pins on the rising edge, output holds until next read.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) sramMem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
      end else begin
        dout0 <= sramMem[addr0];
      end
    end
    if (!csb1) dout1 <= sramMem[addr1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic aV, input logic aWe, input logic [3:0] aMask,
                               input logic [7:0] aAddr, input logic [31:0] aData,
                               input logic bV, input logic [7:0] bAddr);
    a_req_valid = aV;
    a_req_we    = aWe;
    a_req_wmask = aMask;
    a_req_addr  = aAddr;
    a_req_wdata = aData;
    b_req_valid = bV;
    b_req_addr  = bAddr;
  endtask

  task automatic doAWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] mask);
    applyStimulus(1, 1, mask, addr, data, 0, 8'h00);
    #1;
    checkOutput("wr_ready", {31'b0, a_req_ready}, 32'd1);
    step();
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    #1;
    checkOutput("wr_csb0", {31'b0, csb0}, 32'd0);
    checkOutput("wr_web0", {31'b0, web0}, 32'd0);
    checkOutput("wr_wmask0", {28'b0, wmask0}, {28'b0, mask});
    checkOutput("wr_addr0", {24'b0, addr0}, {24'b0, addr});
    checkOutput("wr_din0", din0, data);
  endtask

  task automatic doARead(input logic [7:0] addr, input logic [31:0] expected);
    applyStimulus(1, 0, 4'h0, addr, 32'h0, 0, 8'h00);
    #1;
    checkOutput("rd_ready", {31'b0, a_req_ready}, 32'd1);
    step();
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    #1;
    checkOutput("rd_csb0", {31'b0, csb0}, 32'd0);
    checkOutput("rd_web0", {31'b0, web0}, 32'd1);
    step();
    checkOutput("rd_valid_early", {31'b0, a_rsp_valid}, 32'd0);
    checkOutput("rd_csb0_idle", {31'b0, csb0}, 32'd1);
    step();
    checkOutput("rd_valid", {31'b0, a_rsp_valid}, 32'd1);
    checkOutput("rd_data", a_rsp_rdata, expected);
    step();
    checkOutput("rd_popped", {31'b0, a_rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] gotQ[$];
    logic [31:0] aQ[$];
    logic [31:0] bQ[$];
    logic [31:0] expData;
    logic [7:0]  bAddr;
    int          aCnt, bCnt;
    logic        sawValid, aAcc, bAcc, prevAccA, prevAccB, aHold, bHold;

    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    rst = 1'b1;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);

    // Reset and idle
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checkOutput("rst_csb0", {31'b0, csb0}, 32'd1);
    checkOutput("rst_csb1", {31'b0, csb1}, 32'd1);
    checkOutput("rst_web0", {31'b0, web0}, 32'd1);
    checkOutput("rst_wmask0", {28'b0, wmask0}, 32'd0);
    checkOutput("rst_addr0", {24'b0, addr0}, 32'd0);
    checkOutput("rst_din0", din0, 32'd0);
    checkOutput("rst_a_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    checkOutput("rst_b_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
    checkOutput("rst_a_req_ready", {31'b0, a_req_ready}, 32'd1);
    checkOutput("rst_b_req_ready", {31'b0, b_req_ready}, 32'd1);

    // Full write, read-after-write, partial write, no-op write
    doAWrite(8'h10, 32'hDEADBEEF, 4'hF);
    doARead(8'h10, 32'hDEADBEEF);
    doAWrite(8'h10, 32'h0000AA00, 4'h2);
    doARead(8'h10, 32'hDEADAAEF);
    doAWrite(8'h10, 32'hFFFFFFFF, 4'h0);
    doARead(8'h10, 32'hDEADAAEF);

    // Collision: A writes 0x20 while B reads 0x20
    applyStimulus(1, 1, 4'hF, 8'h20, 32'h12345678, 1, 8'h20);
    #1;
    checkOutput("col_b_ready", {31'b0, b_req_ready}, 32'd0);
    checkOutput("col_a_ready", {31'b0, a_req_ready}, 32'd1);
    step();
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h20);
    #1;
    checkOutput("col_b_retry", {31'b0, b_req_ready}, 32'd1);
    step();
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    #1;
    checkOutput("col_csb1", {31'b0, csb1}, 32'd0);
    checkOutput("col_addr1", {24'b0, addr1}, 32'h20);
    step();
    checkOutput("col_b_valid_early", {31'b0, b_rsp_valid}, 32'd0);
    step();
    checkOutput("col_b_valid", {31'b0, b_rsp_valid}, 32'd1);
    checkOutput("col_b_data", b_rsp_rdata, 32'h12345678);
    step();
    checkOutput("col_b_popped", {31'b0, b_rsp_valid}, 32'd0);
    applyStimulus(1, 1, 4'hF, 8'h21, 32'h0BADF00D, 1, 8'h20);
    #1;
    checkOutput("nocol_b_ready", {31'b0, b_req_ready}, 32'd1);
    step();
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step();

    // B fills its FIFO with backpressure, then drains in order
    b_rsp_ready = 1'b0;
    bAddr = 8'h00;
    bCnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 1, bAddr);
      #1;
      if (b_req_ready) begin
        bCnt++;
        bAddr++;
      end
      step();
    end
    checkOutput("full_accepted", 32'(bCnt), 32'd4);
    #1;
    checkOutput("full_b_ready", {31'b0, b_req_ready}, 32'd0);
    checkOutput("full_b_valid", {31'b0, b_rsp_valid}, 32'd1);
    checkOutput("full_b_hold", b_rsp_rdata, initWord(0));
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 40 && (gotQ.size() < 8 || bAddr < 8); i++) begin
      applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, bAddr < 8, bAddr);
      #1;
      if (b_rsp_valid) gotQ.push_back(b_rsp_rdata);
      if (b_req_valid && b_req_ready) bAddr++;
      step();
    end
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    checkOutput("drain_count", 32'(gotQ.size()), 32'd8);
    for (int i = 0; i < gotQ.size(); i++) checkOutput($sformatf("drain_data%0d", i), gotQ[i], initWord(i));
    step(); step();
    checkOutput("drain_no_dup", {31'b0, b_rsp_valid}, 32'd0);

    // Reset while reads are in flight
    applyStimulus(1, 0, 4'h0, 8'h10, 32'h0, 1, 8'h01);
    #1;
    checkOutput("inflt_a_ready", {31'b0, a_req_ready}, 32'd1);
    checkOutput("inflt_b_ready", {31'b0, b_req_ready}, 32'd1);
    step();
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (a_rsp_valid || b_rsp_valid) sawValid = 1'b1;
      step();
    end
    checkOutput("inflt_discarded", {31'b0, sawValid}, 32'd0);
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    aCnt = 0;
    bCnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 4'h0, 8'h10, 32'h0, 1, 8'h03);
      #1;
      if (a_req_ready) aCnt++;
      if (b_req_ready) bCnt++;
      step();
    end
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    checkOutput("credit_a", 32'(aCnt), 32'd4);
    checkOutput("credit_b", 32'(bCnt), 32'd4);
    #1;
    checkOutput("credit_a_data", a_rsp_rdata, 32'hDEADAAEF);
    checkOutput("credit_b_data", b_rsp_rdata, initWord(3));
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Mixed random traffic against a reference memory on 0x80..0x87
    prevAccA = 1'b0;
    prevAccB = 1'b0;
    aHold = 1'b0;
    bHold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!aHold) begin
        a_req_valid = 1'($urandom_range(0, 1));
        a_req_we    = 1'($urandom_range(0, 1));
        a_req_wmask = 4'($urandom_range(0, 15));
        a_req_addr  = 8'h80 | 8'($urandom_range(0, 7));
        a_req_wdata = $urandom;
      end
      if (!bHold) begin
        b_req_valid = 1'($urandom_range(0, 1));
        b_req_addr  = 8'h80 | 8'($urandom_range(0, 7));
      end
      a_rsp_ready = ($urandom_range(0, 3) != 0);
      b_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checkOutput("rand_csb0", {31'b0, csb0}, {31'b0, ~prevAccA});
      checkOutput("rand_csb1", {31'b0, csb1}, {31'b0, ~prevAccB});
      if (a_rsp_valid && a_rsp_ready) begin
        if (aQ.size() == 0) checkOutput("randA_spurious", {31'b0, a_rsp_valid}, 32'd0);
        else begin
          expData = aQ.pop_front();
          checkOutput("randA_data", a_rsp_rdata, expData);
        end
      end
      if (b_rsp_valid && b_rsp_ready) begin
        if (bQ.size() == 0) checkOutput("randB_spurious", {31'b0, b_rsp_valid}, 32'd0);
        else begin
          expData = bQ.pop_front();
          checkOutput("randB_data", b_rsp_rdata, expData);
        end
      end
      aAcc = a_req_valid && a_req_ready;
      bAcc = b_req_valid && b_req_ready;
      if (bAcc) bQ.push_back(refMem[b_req_addr]);
      if (aAcc && !a_req_we) aQ.push_back(refMem[a_req_addr]);
      if (aAcc && a_req_we)
        for (int b = 0; b < 4; b++)
          if (a_req_wmask[b]) refMem[a_req_addr][b*8 +: 8] = a_req_wdata[b*8 +: 8];
      aHold = a_req_valid && !aAcc;
      bHold = b_req_valid && !bAcc;
      prevAccA = aAcc;
      prevAccB = bAcc;
      step();
    end
    applyStimulus(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (a_rsp_valid) begin
        if (aQ.size() == 0) checkOutput("drainA_spurious", {31'b0, a_rsp_valid}, 32'd0);
        else begin
          expData = aQ.pop_front();
          checkOutput("drainA_data", a_rsp_rdata, expData);
        end
      end
      if (b_rsp_valid) begin
        if (bQ.size() == 0) checkOutput("drainB_spurious", {31'b0, b_rsp_valid}, 32'd0);
        else begin
          expData = bQ.pop_front();
          checkOutput("drainB_data", b_rsp_rdata, expData);
        end
      end
      step();
    end
    checkOutput("randA_left", 32'(aQ.size()), 32'd0);
    checkOutput("randB_left", 32'(bQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
